// File: rtl/lcd_timing_gen.sv
// Parametrised TFT panel timing generator with power sequencing.
// Derives the pixel clock from clk, generates sync/DE decode and the
// active-area coordinates, and walks the panel through power-up/down.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// OFF       | panel unpowered, timing stopped
// PWR_WAIT  | logic supply on, waiting PWR_DLY before DISP
// BL_WAIT   | DISP on, timing running, waiting BL_DLY before backlight
// RUN       | backlight on, steady state
// SHUTDOWN  | backlight off, finish frame, drop DISP, hold supply PWR_DLY
module lcd_timing_gen #(
   parameter int CLK_DIV  = 6,
   parameter int H_SYNC   = 41,
   parameter int H_BP     = 2,
   parameter int H_ACTIVE = 480,
   parameter int H_FP     = 2,
   parameter int V_SYNC   = 10,
   parameter int V_BP     = 2,
   parameter int V_ACTIVE = 272,
   parameter int V_FP     = 4,
   parameter int PWR_DLY  = 3750000,
   parameter int BL_DLY   = 12000000,
   parameter int HW       = 10,
   parameter int VW       = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   output logic          tft_clk,
   output logic          tft_en,
   output logic          tft_display,
   output logic          led_en,
   output logic          tft_de,
   output logic          tft_hsync_n,
   output logic          tft_vsync_n,
   output logic [HW-1:0] h_count,
   output logic [VW-1:0] v_count,
   output logic          pix_ce,
   output logic          line_start,
   output logic          frame_start,
   output logic          ready
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int DLY_MAX = (PWR_DLY > BL_DLY) ? PWR_DLY : BL_DLY;
   localparam int DLYW    = $clog2(DLY_MAX + 1);
   localparam int DIVW    = $clog2(CLK_DIV);

   // One extra bit so window bounds equal to 2**HW / 2**VW stay representable.
   localparam logic [HW:0] H_SYNC_END = (HW+1)'(H_SYNC);
   localparam logic [HW:0] H_DE_LO    = (HW+1)'(H_SYNC + H_BP);
   localparam logic [HW:0] H_DE_HI    = (HW+1)'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [VW:0] V_SYNC_END = (VW+1)'(V_SYNC);
   localparam logic [VW:0] V_DE_LO    = (VW+1)'(V_SYNC + V_BP);
   localparam logic [VW:0] V_DE_HI    = (VW+1)'(V_SYNC + V_BP + V_ACTIVE);

   localparam logic [2:0] ST_OFF      = 3'd0;
   localparam logic [2:0] ST_PWR_WAIT = 3'd1;
   localparam logic [2:0] ST_BL_WAIT  = 3'd2;
   localparam logic [2:0] ST_RUN      = 3'd3;
   localparam logic [2:0] ST_SHUTDOWN = 3'd4;

   if (H_TOTAL > (1 << HW)) begin : g_bad_hw
      $error("lcd_timing_gen: H_TOTAL does not fit in HW bits");
   end
   if (V_TOTAL > (1 << VW)) begin : g_bad_vw
      $error("lcd_timing_gen: V_TOTAL does not fit in VW bits");
   end
   if (CLK_DIV < 2) begin : g_bad_div
      $error("lcd_timing_gen: CLK_DIV must be at least 2");
   end

   logic [2:0]      state;
   logic [DLYW-1:0] dly;
   logic            running;
   logic            disp;
   logic [DIVW-1:0] div;
   logic [HW-1:0]   h;
   logic [VW-1:0]   v;
   logic            pwr_done;
   logic            bl_done;
   logic            h_in;
   logic            v_in;

   assign pwr_done    = (dly == DLYW'(PWR_DLY - 1));
   assign bl_done     = (dly == DLYW'(BL_DLY - 1));
   assign pix_ce      = running && (div == DIVW'(CLK_DIV - 1));
   assign line_start  = pix_ce && (h == HW'(H_TOTAL - 1));
   assign frame_start = line_start && (v == VW'(V_TOTAL - 1));

   // Power sequencing FSM; delay counter restarts on every state entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_OFF;
         dly     <= '0;
         running <= 1'b0;
         disp    <= 1'b0;
      end else begin
         case (state)
            ST_OFF: begin
               if (enable) begin
                  state <= ST_PWR_WAIT;
                  dly   <= '0;
               end
            end
            ST_PWR_WAIT: begin
               if (!enable) begin
                  state <= ST_SHUTDOWN;
                  dly   <= '0;
               end else if (pwr_done) begin
                  state   <= ST_BL_WAIT;
                  dly     <= '0;
                  disp    <= 1'b1;
                  running <= 1'b1;
               end else begin
                  dly <= dly + 1'b1;
               end
            end
            ST_BL_WAIT: begin
               if (!enable) begin
                  state <= ST_SHUTDOWN;
                  dly   <= '0;
               end else if (bl_done) begin
                  state <= ST_RUN;
                  dly   <= '0;
               end else begin
                  dly <= dly + 1'b1;
               end
            end
            ST_RUN: begin
               if (!enable) begin
                  state <= ST_SHUTDOWN;
                  dly   <= '0;
               end
            end
            ST_SHUTDOWN: begin
               // Let the current frame complete so the panel never sees a torn frame.
               if (running) begin
                  if (frame_start) begin
                     running <= 1'b0;
                     disp    <= 1'b0;
                  end
               end else if (pwr_done) begin
                  state <= ST_OFF;
                  dly   <= '0;
               end else begin
                  disp <= 1'b0;
                  dly  <= dly + 1'b1;
               end
            end
            default: begin
               state   <= ST_OFF;
               dly     <= '0;
               running <= 1'b0;
               disp    <= 1'b0;
            end
         endcase
      end
   end

   // Pixel divider and raster counters; held at zero whenever timing is stopped.
   always_ff @(posedge clk) begin
      if (rst || !running) begin
         div <= '0;
         h   <= '0;
         v   <= '0;
      end else if (pix_ce) begin
         div <= '0;
         if (line_start) begin
            h <= '0;
            v <= frame_start ? '0 : v + 1'b1;
         end else begin
            h <= h + 1'b1;
         end
      end else begin
         div <= div + 1'b1;
      end
   end

   // Zero-latency decode from the registered raster position.
   always_comb begin
      h_in        = ({1'b0, h} >= H_DE_LO) && ({1'b0, h} < H_DE_HI);
      v_in        = ({1'b0, v} >= V_DE_LO) && ({1'b0, v} < V_DE_HI);
      tft_de      = running && h_in && v_in;
      tft_hsync_n = !(running && ({1'b0, h} < H_SYNC_END));
      tft_vsync_n = !(running && ({1'b0, v} < V_SYNC_END));
      h_count     = tft_de ? (h - H_DE_LO[HW-1:0]) : '0;
      v_count     = tft_de ? (v - V_DE_LO[VW-1:0]) : '0;
      tft_clk     = running && (div < DIVW'(CLK_DIV / 2));
      tft_en      = (state != ST_OFF);
      tft_display = disp;
      led_en      = (state == ST_RUN);
      ready       = (state == ST_RUN);
   end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: scripted sequences with hand-derived constants
// plus a continuously running arithmetic reference model under random enable/reset.
module tb_lcd_timing_gen;

   localparam int CLK_DIV  = 4;
   localparam int H_SYNC   = 2;
   localparam int H_BP     = 2;
   localparam int H_ACTIVE = 8;
   localparam int H_FP     = 2;
   localparam int V_SYNC   = 1;
   localparam int V_BP     = 1;
   localparam int V_ACTIVE = 4;
   localparam int V_FP     = 1;
   localparam int PWR_DLY  = 10;
   localparam int BL_DLY   = 20;
   localparam int HW       = 10;
   localparam int VW       = 9;
   localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int FRAME_CLKS = CLK_DIV * H_TOTAL * V_TOTAL;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          tft_clk, tft_en, tft_display, led_en, tft_de;
   logic          tft_hsync_n, tft_vsync_n;
   logic [HW-1:0] h_count;
   logic [VW-1:0] v_count;
   logic          pix_ce, line_start, frame_start, ready;

   int total = 0;
   int bad   = 0;

   lcd_timing_gen #(
      .CLK_DIV(CLK_DIV), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
      .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP),
      .PWR_DLY(PWR_DLY), .BL_DLY(BL_DLY), .HW(HW), .VW(VW)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .tft_clk(tft_clk), .tft_en(tft_en), .tft_display(tft_display), .led_en(led_en),
      .tft_de(tft_de), .tft_hsync_n(tft_hsync_n), .tft_vsync_n(tft_vsync_n),
      .h_count(h_count), .v_count(v_count), .pix_ce(pix_ce),
      .line_start(line_start), .frame_start(frame_start), .ready(ready)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
      end
   endtask

   function automatic logic [29:0] dut_vec();
      return {tft_en, tft_display, led_en, ready, tft_clk, pix_ce, line_start, frame_start,
              tft_hsync_n, tft_vsync_n, tft_de, h_count, v_count};
   endfunction

   // ---------------- reference model ----------------
   // ph: 0 off, 1 power wait, 2 backlight wait, 3 run, 4 shutdown.
   // tr: clocks since timing started (-1 when stopped); raster derived arithmetically.
   int m_ph = 0, m_left = 0, m_tr = -1;
   bit m_disp = 0, m_valid = 0;

   function automatic bit model_fs(input int tr);
      return (tr >= 0) && ((tr % FRAME_CLKS) == FRAME_CLKS - 1);
   endfunction

   function automatic logic [29:0] model_out(input int ph, input int tr, input bit disp);
      int d, p, hh, vv;
      bit tc, pce, ls, fs, hs_n, vs_n, de;
      logic [HW-1:0] hc;
      logic [VW-1:0] vc;
      tc = 0; pce = 0; ls = 0; fs = 0; hs_n = 1; vs_n = 1; de = 0; hc = '0; vc = '0;
      if (tr >= 0) begin
         d    = tr % CLK_DIV;
         p    = tr / CLK_DIV;
         hh   = p % H_TOTAL;
         vv   = (p / H_TOTAL) % V_TOTAL;
         tc   = d < CLK_DIV / 2;
         pce  = d == CLK_DIV - 1;
         ls   = pce && hh == H_TOTAL - 1;
         fs   = ls && vv == V_TOTAL - 1;
         hs_n = !(hh < H_SYNC);
         vs_n = !(vv < V_SYNC);
         de   = hh >= H_SYNC + H_BP && hh < H_SYNC + H_BP + H_ACTIVE &&
                vv >= V_SYNC + V_BP && vv < V_SYNC + V_BP + V_ACTIVE;
         if (de) begin
            hc = HW'(hh - (H_SYNC + H_BP));
            vc = VW'(vv - (V_SYNC + V_BP));
         end
      end
      return {ph != 0, disp, ph == 3, ph == 3, tc, pce, ls, fs, hs_n, vs_n, de, hc, vc};
   endfunction

   // Advance the model on each clk edge from the inputs the DUT sees.
   always @(posedge clk) begin
      bit fs;
      fs = model_fs(m_tr);
      if (rst) begin
         m_ph = 0; m_left = 0; m_tr = -1; m_disp = 0; m_valid = 1;
      end else if (m_valid) begin
         if (m_tr >= 0) m_tr++;
         case (m_ph)
            0: if (enable) begin m_ph = 1; m_left = PWR_DLY; end
            1: if (!enable) begin m_ph = 4; m_left = PWR_DLY; end
               else if (m_left == 1) begin m_ph = 2; m_left = BL_DLY; m_disp = 1; m_tr = 0; end
               else m_left--;
            2: if (!enable) begin m_ph = 4; m_left = PWR_DLY; end
               else if (m_left == 1) m_ph = 3;
               else m_left--;
            3: if (!enable) begin m_ph = 4; m_left = PWR_DLY; end
            default: begin
               if (m_tr >= 0) begin
                  if (fs) begin m_tr = -1; m_disp = 0; end
               end else if (m_left == 1) m_ph = 0;
               else m_left--;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      logic [29:0] want, got;
      if (m_valid) begin
         want = model_out(m_ph, m_tr, m_disp);
         got  = dut_vec();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL model: got %h want %h at %0t", got, want, $time);
         end
      end
   end

   // ---------------- scripted table ----------------
   typedef struct {
      int t;
      bit tc, pce, ls, fs, hs_n, vs_n, de, led;
      int hc, vc;
   } vec_t;

   vec_t tbl[$];

   initial begin
      int cur, n, cnt_pce, cnt_ls, cnt_fs, cnt_de, cnt_hs, cnt_vs, first_ls, stray, clk_hi, disp_seen;
      bit en_tog;
      tbl = '{
         '{0,   1,0,0,0, 0,0,0, 0, 0,0},
         '{1,   1,0,0,0, 0,0,0, 0, 0,0},
         '{2,   0,0,0,0, 0,0,0, 0, 0,0},
         '{3,   0,1,0,0, 0,0,0, 0, 0,0},
         '{8,   1,0,0,0, 1,0,0, 0, 0,0},
         '{16,  1,0,0,0, 1,0,0, 0, 0,0},
         '{19,  0,1,0,0, 1,0,0, 0, 0,0},
         '{20,  1,0,0,0, 1,0,0, 1, 0,0},
         '{55,  0,1,1,0, 1,0,0, 1, 0,0},
         '{56,  1,0,0,0, 0,1,0, 1, 0,0},
         '{128, 1,0,0,0, 1,1,1, 1, 0,0},
         '{156, 1,0,0,0, 1,1,1, 1, 7,0},
         '{160, 1,0,0,0, 1,1,0, 1, 0,0},
         '{299, 0,1,0,0, 1,1,1, 1, 0,3},
         '{364, 1,0,0,0, 1,1,0, 1, 0,0},
         '{391, 0,1,1,1, 1,1,0, 1, 0,0},
         '{392, 1,0,0,0, 0,0,0, 1, 0,0}
      };

      rst = 1; enable = 0;
      tick(2);
      check("rst_tft_en", tft_en, 0);
      check("rst_hsync_n", tft_hsync_n, 1);
      check("rst_vsync_n", tft_vsync_n, 1);
      check("rst_tft_clk", tft_clk, 0);
      rst = 0;
      tick(1);
      check("off_idle_en", tft_en, 0);

      // Power-up sequence.
      enable = 1;
      tick(1);
      check("pwr_tft_en", tft_en, 1);
      check("pwr_disp_early", tft_display, 0);
      tick(9);
      check("pwr_disp_at9", tft_display, 0);
      tick(1);
      check("pwr_disp_at10", tft_display, 1);
      check("pwr_led_off", led_en, 0);

      cur = 0;
      foreach (tbl[i]) begin
         tick(tbl[i].t - cur);
         cur = tbl[i].t;
         check($sformatf("tbl%0d_clk", tbl[i].t), tft_clk, tbl[i].tc);
         check($sformatf("tbl%0d_pce", tbl[i].t), pix_ce, tbl[i].pce);
         check($sformatf("tbl%0d_ls", tbl[i].t), line_start, tbl[i].ls);
         check($sformatf("tbl%0d_fs", tbl[i].t), frame_start, tbl[i].fs);
         check($sformatf("tbl%0d_hs", tbl[i].t), tft_hsync_n, tbl[i].hs_n);
         check($sformatf("tbl%0d_vs", tbl[i].t), tft_vsync_n, tbl[i].vs_n);
         check($sformatf("tbl%0d_de", tbl[i].t), tft_de, tbl[i].de);
         check($sformatf("tbl%0d_led", tbl[i].t), led_en, tbl[i].led);
         check($sformatf("tbl%0d_rdy", tbl[i].t), ready, tbl[i].led);
         check($sformatf("tbl%0d_hc", tbl[i].t), h_count, tbl[i].hc);
         check($sformatf("tbl%0d_vc", tbl[i].t), v_count, tbl[i].vc);
      end

      // One full frame of statistics starting at a frame boundary.
      cnt_pce = 0; cnt_ls = 0; cnt_fs = 0; cnt_de = 0; cnt_hs = 0; cnt_vs = 0;
      first_ls = -1; stray = 0;
      for (int i = 0; i < FRAME_CLKS; i++) begin
         cnt_pce += pix_ce;
         cnt_ls  += line_start;
         cnt_fs  += frame_start;
         cnt_de  += tft_de;
         cnt_hs  += !tft_hsync_n;
         cnt_vs  += !tft_vsync_n;
         if (line_start && first_ls < 0) first_ls = i;
         if (!tft_de && (h_count != 0 || v_count != 0)) stray++;
         tick(1);
      end
      cur = 2 * FRAME_CLKS;
      check("frame_pix_ce", cnt_pce, 98);
      check("frame_line_start", cnt_ls, 7);
      check("frame_frame_start", cnt_fs, 1);
      check("frame_de_clks", cnt_de, 32 * CLK_DIV);
      check("frame_hsync_low", cnt_hs, 7 * 2 * CLK_DIV);
      check("frame_vsync_low", cnt_vs, 14 * CLK_DIV);
      check("frame_first_ls", first_ls, 55);
      check("frame_count_stray", stray, 0);

      // Drop enable mid-frame at v=3, h=2.
      tick(960 - cur);
      enable = 0;
      tick(1);
      check("sd_led_off", led_en, 0);
      check("sd_ready_off", ready, 0);
      check("sd_disp_held", tft_display, 1);
      check("sd_tft_en_held", tft_en, 1);
      n = 0;
      while (!frame_start && n < 1000) begin
         tick(1);
         n++;
      end
      check("sd_wait_to_fs", n, 214);
      tick(1);
      check("sd_disp_off", tft_display, 0);
      check("sd_tft_clk_off", tft_clk, 0);
      clk_hi = 0;
      for (int i = 0; i < 9; i++) begin
         tick(1);
         clk_hi += tft_clk;
      end
      check("sd_tft_clk_stuck", clk_hi, 0);
      check("sd_tft_en_hold", tft_en, 1);
      tick(1);
      check("sd_tft_en_off", tft_en, 0);

      // Drop enable during PWR_WAIT at delay count 5.
      enable = 1;
      disp_seen = 0;
      tick(1);
      check("abort_tft_en", tft_en, 1);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         disp_seen += tft_display;
      end
      enable = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         disp_seen += tft_display;
      end
      check("abort_no_disp", disp_seen, 0);
      check("abort_tft_en_held", tft_en, 1);
      tick(1);
      check("abort_tft_en_off", tft_en, 0);

      // Reset while running at h=7, v=4.
      enable = 1;
      tick(1 + PWR_DLY + BL_DLY);
      check("rr_ready", ready, 1);
      tick(233);
      check("rr_de", tft_de, 1);
      check("rr_hc", h_count, 3);
      check("rr_vc", v_count, 2);
      rst = 1;
      tick(1);
      check("rr_reset_vec", dut_vec(), 30'h00000000 | (30'h1 << 21) | (30'h1 << 20));
      rst = 0;
      tick(1);
      check("rr_resume_en", tft_en, 1);
      check("rr_resume_disp", tft_display, 0);

      // Random enable/reset activity checked against the model every cycle.
      en_tog = 1;
      for (int blk = 0; blk < 40; blk++) begin
         if ($urandom_range(0, 7) == 0) begin
            rst = 1;
            tick(1);
            rst = 0;
         end
         en_tog = !en_tog;
         enable = en_tog;
         tick($urandom_range(0, 1) ? $urandom_range(1, 40) : $urandom_range(40, 600));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
- Parametrised successor to the fixed 480x272 TFT controller.
- Single-clock design. The pixel clock is derived internally from `clk` by an integer divider.
- Porch, sync and active widths are programmable. Adds hsync/vsync outputs and line/frame strobes.
- Full power-up and power-down sequencing under an `enable` request.
- Sits between the system clock and the panel. The glyph/pixel renderer consumes `h_count`, `v_count` and `tft_de`.

Parameters:
- CLK_DIV, 6: clk cycles per pixel; must be >= 2.
- H_SYNC, 41: hsync width, pixels.
- H_BP, 2: horizontal back porch, pixels.
- H_ACTIVE, 480: visible pixels per line.
- H_FP, 2: horizontal front porch, pixels.
- V_SYNC, 10: vsync width, lines.
- V_BP, 2: vertical back porch, lines.
- V_ACTIVE, 272: visible lines.
- V_FP, 4: vertical front porch, lines.
- PWR_DLY, 3750000: clk cycles from enable to display-on. Also used as the power-down hold.
- BL_DLY, 12000000: clk cycles from display-on to backlight-on.
- HW, 10: width of h counter and `h_count`.
- VW, 9: width of v counter and `v_count`.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  level request for the panel to be on.
- tft_clk  out  1  pixel clock to the panel.
- tft_en  out  1  panel logic supply enable.
- tft_display  out  1  panel DISP signal.
- led_en  out  1  backlight enable.
- tft_de  out  1  data enable; high inside the active window.
- tft_hsync_n  out  1  active-low hsync.
- tft_vsync_n  out  1  active-low vsync.
- h_count  out  HW  active-area column, 0..H_ACTIVE-1; 0 outside the window.
- v_count  out  VW  active-area row, 0..V_ACTIVE-1; 0 outside the window.
- pix_ce  out  1  one-clk strobe per pixel period.
- line_start  out  1  one-clk strobe on horizontal wrap.
- frame_start  out  1  one-clk strobe on frame wrap.
- ready  out  1  high in RUN only.

Behaviour:
- Reset (rst=1 at a clk edge) takes priority over everything, including mid-sequence.
  - state=OFF; div, h, v, delay counter = 0.
  - All outputs 0, except tft_hsync_n=1 and tft_vsync_n=1.
- Derived totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
  - Elaboration-time checks: H_TOTAL must fit in HW bits; V_TOTAL must fit in VW bits.
- FSM states: OFF, PWR_WAIT, BL_WAIT, RUN, SHUTDOWN. The delay counter clears on every state entry.
  - OFF: everything idle. enable=1 -> PWR_WAIT.
  - PWR_WAIT: tft_en=1. On the cycle the delay counter reaches PWR_DLY-1:
    - tft_display=1 registered on the next edge;
    - timing starts (div, h, v begin counting from 0);
    - -> BL_WAIT.
  - BL_WAIT: timing running. After BL_DLY cycles, led_en=1 and ready=1 -> RUN.
  - RUN: steady state.
  - enable=0 in PWR_WAIT, BL_WAIT or RUN -> SHUTDOWN on the next edge.
  - SHUTDOWN:
    - led_en=0 and ready=0 immediately.
    - Timing keeps running until frame_start, then stops and clears.
    - tft_display=0, then hold PWR_DLY cycles with tft_en=1.
    - -> OFF.
    - If timing never started (entered from PWR_WAIT), the frame wait is skipped.
  - enable=1 during SHUTDOWN is ignored until OFF is reached; OFF then re-enters PWR_WAIT on the next cycle.
- Timing engine (only while running; otherwise div/h/v held at 0):
  - div counts 0..CLK_DIV-1 and wraps. pix_ce=1 when div==CLK_DIV-1.
  - tft_clk=1 while div < CLK_DIV/2 (integer divide). It is held 0 when timing is stopped.
  - On pix_ce, h increments. At H_TOTAL-1, h wraps to 0 and v increments. At V_TOTAL-1, v wraps to 0.
  - line_start = pix_ce & (h==H_TOTAL-1). frame_start = line_start & (v==V_TOTAL-1).
- Decode, combinational from the registered h/v, zero latency:
  - tft_hsync_n=0 iff h < H_SYNC.
  - tft_vsync_n=0 iff v < V_SYNC.
  - tft_de=1 iff H_SYNC+H_BP <= h < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= v < V_SYNC+V_BP+V_ACTIVE.
  - While tft_de=1: h_count = h-(H_SYNC+H_BP) and v_count = v-(V_SYNC+V_BP), truncated to HW/VW.
  - Zero-width porches (H_FP=0 etc.) are legal. The active window then abuts the wrap.

Test Plan:
- Common sim parameters: CLK_DIV=4; H 2/2/8/2 (H_TOTAL=14); V 1/1/4/1 (V_TOTAL=7); PWR_DLY=10; BL_DLY=20.
- Reset then enable=1 -> tft_en=1 next cycle; tft_display=1 after 10 clks; led_en=1 and ready=1 after a further 20 clks; tft_clk pattern 1,1,0,0.
- Free run one frame -> exactly 98 pix_ce per frame; line_start every 56 clks; frame_start every 392 clks; hsync_n low 2 pixels/line; vsync_n low for the first 14 pixels (1 line) of each frame.
- Active window -> tft_de high for h=4..11 on v=2..5, i.e. 32 pixels/frame; h_count 0..7; v_count 0..3; both 0 when de=0.
- Drop enable mid-frame at v=3 -> led_en=0 next clk; timing continues to frame_start; then tft_display=0, tft_clk stuck 0, tft_en=0 after 10 more clks; state OFF.
- Drop enable during PWR_WAIT at delay count 5 -> no tft_display pulse; tft_en=0 10 clks after entering SHUTDOWN.
- Assert rst while in RUN at h=7, v=4 -> next edge: all outputs at reset values, syncs=1, counters 0; with enable held high, PWR_WAIT resumes one cycle after rst releases.
